// File: rtl/alu_mul_seq.sv
// ============================================================================
// alu_mul_seq : sequential shift-and-add multiplier driving a shared ALU
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_busA,
  output logic [WIDTH-1:0] alu_busB,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [2:0]       C_NOP  = 3'b000;
  localparam logic [2:0]       C_ADD  = 3'b001;
  localparam logic [2:0]       C_SLL  = 3'b111;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDP = 2'd1,
    S_SHFT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mult;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    ready    = 1'b0;
    done     = 1'b0;
    alu_ctrl = C_NOP;
    alu_busA = '0;
    alu_busB = '0;
    unique case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_next = S_ADDP;
      end
      S_ADDP: begin
        // Skip the ALU entirely when this multiplier bit is zero.
        if (r_mult[0]) begin
          alu_ctrl = C_ADD;
          alu_busA = r_acc;
          alu_busB = r_mcand;
        end
        w_next = S_SHFT;
      end
      S_SHFT: begin
        alu_ctrl = C_SLL;
        alu_busA = r_mcand;
        alu_busB = WIDTH'(1);
        w_next   = (r_cnt == C_LAST) ? S_DONE : S_ADDP;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mult    <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_mcand <= op_a;
            r_mult  <= op_b;
            r_cnt   <= '0;
          end
        end
        S_ADDP: begin
          if (r_mult[0]) r_acc <= alu_out;
        end
        S_SHFT: begin
          r_mcand <= alu_out;
          r_mult  <= r_mult >> 1;
          r_cnt   <= r_cnt + 1'b1;
        end
        S_DONE: begin
          r_product <= r_acc;
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural ALU beside it.
`default_nettype none

module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        ready, done;
  logic [31:0] product;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_busA, alu_busB, alu_out;

  alu_mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .ready(ready), .done(done), .product(product), .alu_ctrl(alu_ctrl),
    .alu_busA(alu_busA), .alu_busB(alu_busB), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  assign alu_out = (alu_ctrl == 3'b001) ? alu_busA + alu_busB :
                   (alu_ctrl == 3'b111) ? alu_busA << alu_busB[4:0] : 32'h0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] prod;
    int          done_cyc;
  } exp_t;
  exp_t        q[$];
  logic        pend = 1'b0;
  logic [31:0] pend_prod;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("product", {32'h0, product}, {32'h0, pend_prod});
        chk("ready_after_done", {63'h0, ready}, 64'h1);
        chk("done_one_cycle", {63'h0, done}, 64'h0);
        pend = 1'b0;
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", {63'h0, done}, 64'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
          chk("ready_in_done", {63'h0, ready}, 64'h0);
          pend      = 1'b1;
          pend_prod = e.prod;
        end
      end
    end
  end

  // Called at a negedge; drives start for one cycle once ready is seen.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, output int t);
    int n;
    exp_t e;
    n = 0;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", {63'h0, ready}, 64'h1);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    t     = cyc;
    e.prod     = exp;
    e.done_cyc = t + 65;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || pend) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(q.size()) + {63'h0, pend}, 64'h0);
  endtask

  // Entered at the first ADDP cycle; mult_bits gives the expected ADD/NOP pattern.
  task automatic chk_ctrl_seq(input string name, input logic [31:0] mult_bits);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) begin
        if (alu_ctrl !== (mult_bits[i/2] ? 3'b001 : 3'b000)) bad++;
      end else begin
        if (alu_ctrl !== 3'b111 || alu_busB !== 32'h1) bad++;
      end
      @(negedge clk);
    end
    chk(name, 64'(bad), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = 32'h0;
    op_b  = 32'h0;
    #1;
    chk("rst_ready", {63'h0, ready}, 64'h1);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_ctrl", {61'h0, alu_ctrl}, 64'h0);
    chk("rst_buses", {alu_busA, alu_busB}, 64'h0);
    chk("rst_product", {32'h0, product}, 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'd3, 32'd5, 32'd15, t);
    chk("busy_not_ready", {63'h0, ready}, 64'h0);
    wait_drain();

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, t);
    chk_ctrl_seq("ctrl_seq_ones", 32'hFFFF_FFFF);
    wait_drain();

    issue(32'h0001_0000, 32'h0001_0000, 32'h0, t);
    wait_drain();
    issue(32'h1234_5678, 32'h0, 32'h0, t);
    chk_ctrl_seq("ctrl_seq_zero", 32'h0);
    wait_drain();

    issue(32'd7, 32'd11, 32'd77, t);
    while (cyc < t + 10) @(negedge clk);
    start = 1'b1; op_a = 32'd100; op_b = 32'd100;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t + 65) @(negedge clk);
    chk("in_done_cycle", {63'h0, done}, 64'h1);
    start = 1'b1; op_a = 32'd5; op_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_start_ignored", {63'h0, ready}, 64'h1);
    wait_drain();

    issue(32'd3, 32'd3, 32'd9, t);
    while (cyc < t + 20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {63'h0, ready}, 64'h1);
    chk("abort_product", {32'h0, product}, 64'h0);
    chk("abort_ctrl", {61'h0, alu_ctrl}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    chk("abort_product_held", {32'h0, product}, 64'h0);
    issue(32'd7, 32'd6, 32'd42, t);
    wait_drain();

    issue(32'd9, 32'd9, 32'd81, t);
    issue(32'd2, 32'h8000_0000, 32'h0, t2);
    chk("b2b_start", 64'(t2), 64'(t + 66));
    wait_drain();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
